// File: rtl/fu_wb_arbiter_if.sv
// fu_wb_arbiter_if
//   Bundles the functional-unit completion side and the register-file write
//   side of the write-back arbiter.
//   Handshake: fu_finish[i] is a one-cycle valid with no ready. fu_hold[i]
//   is the back-pressure: while it is 1 the scoreboard must not issue to
//   unit i. When it is 0, unit i may finish in that same cycle without
//   losing its result. retire_valid/retire_fu report the one result
//   written back in the current cycle. There is no ready on the write side.
//   Modports:
//     master - functional-unit / scoreboard / register-file side
//     slave  - the arbiter
interface fu_wb_arbiter_if #(
  parameter int NUM_FU = 5,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int ID_W   = 3
);
  logic [NUM_FU-1:0]        fu_finish;
  logic [NUM_FU*ADDR_W-1:0] fu_rd;
  logic [NUM_FU*DATA_W-1:0] fu_data;
  logic [NUM_FU-1:0]        fu_hold;
  logic                     wb_en;
  logic [ADDR_W-1:0]        wb_addr;
  logic [DATA_W-1:0]        wb_data;
  logic                     retire_valid;
  logic [ID_W-1:0]          retire_fu;
  logic                     overflow;

  modport master (
    output fu_finish, fu_rd, fu_data,
    input  fu_hold, wb_en, wb_addr, wb_data, retire_valid, retire_fu, overflow
  );

  modport slave (
    input  fu_finish, fu_rd, fu_data,
    output fu_hold, wb_en, wb_addr, wb_data, retire_valid, retire_fu, overflow
  );
endinterface

// File: rtl/fu_wb_arbiter.sv
// fu_wb_arbiter
//   Captures each functional unit's finish pulse into a per-unit one-entry
//   buffer and grants one buffered result per cycle, round-robin, onto the
//   single register-file write port.
//   Ports:
//     clk     - clock, all state updates on posedge
//     rst     - synchronous active-high reset
//     bus     - fu_wb_arbiter_if.slave (finish/rd/data in; hold, write
//               port, retire report and sticky overflow out)
//     dbg_ptr - current round-robin pointer, for observation only
module fu_wb_arbiter #(
  parameter int NUM_FU = 5,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int ID_W   = 3
) (
  input  logic            clk,
  input  logic            rst,
  fu_wb_arbiter_if.slave  bus,
  output logic [ID_W-1:0] dbg_ptr
);

  localparam logic [ID_W:0]   NUM_FU_W = (ID_W+1)'(NUM_FU);
  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_FU - 1);

  logic [NUM_FU-1:0] v_q, v_d;
  logic [ADDR_W-1:0] rd_q   [NUM_FU];
  logic [ADDR_W-1:0] rd_d   [NUM_FU];
  logic [DATA_W-1:0] data_q [NUM_FU];
  logic [DATA_W-1:0] data_d [NUM_FU];
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              overflow_q, overflow_d;

  logic              grant_vld;
  logic [ID_W-1:0]   grant_idx;
  logic [NUM_FU-1:0] gnt_oh;
  logic [ID_W:0]     scan;

  // Round-robin pick: walk ptr, ptr+1, ... modulo NUM_FU and take the first
  // valid buffer. ptr always stays below NUM_FU, so one subtraction wraps.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan      = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      scan = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (scan >= NUM_FU_W) scan = scan - NUM_FU_W;
      if (!grant_vld && v_q[scan[ID_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = scan[ID_W-1:0];
      end
    end
    gnt_oh = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      gnt_oh[i] = grant_vld && (grant_idx == ID_W'(i));
    end
  end

  // Outputs depend on state only; a finish never retires in its own cycle.
  always_comb begin
    bus.retire_valid = grant_vld;
    bus.retire_fu    = grant_vld ? grant_idx : '0;
    bus.wb_addr      = grant_vld ? rd_q[grant_idx] : '0;
    bus.wb_data      = grant_vld ? data_q[grant_idx] : '0;
    // x0 results still retire and free the buffer, but never write.
    bus.wb_en        = grant_vld && (rd_q[grant_idx] != '0);
    bus.fu_hold      = v_q & ~gnt_oh;
    bus.overflow     = overflow_q;
    dbg_ptr          = ptr_q;
  end

  // Buffer update. A buffer being granted this cycle may be refilled in the
  // same cycle; a finish into an occupied, ungranted buffer is dropped and
  // the older result kept.
  always_comb begin
    v_d        = v_q;
    rd_d       = rd_q;
    data_d     = data_q;
    overflow_d = overflow_q;
    ptr_d      = ptr_q;
    for (int i = 0; i < NUM_FU; i++) begin
      if (bus.fu_finish[i]) begin
        if (!v_q[i] || gnt_oh[i]) begin
          v_d[i]    = 1'b1;
          rd_d[i]   = bus.fu_rd[i*ADDR_W +: ADDR_W];
          data_d[i] = bus.fu_data[i*DATA_W +: DATA_W];
        end else begin
          overflow_d = 1'b1;
        end
      end else if (gnt_oh[i]) begin
        v_d[i] = 1'b0;
      end
    end
    if (grant_vld) begin
      ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + ID_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q        <= '0;
      ptr_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      v_q        <= v_d;
      ptr_q      <= ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Payload registers need no reset: they are only observed while v is set.
  always_ff @(posedge clk) begin
    rd_q   <= rd_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// tb_fu_wb_arbiter
//   Directed scenarios followed by randomized traffic, checked against a
//   behavioural model of the per-unit buffers, pointer and overflow flag.
module tb_fu_wb_arbiter;
  localparam int NF = 5;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int IW = 3;

  logic          clk;
  logic          rst;
  logic [IW-1:0] dbg_ptr;
  int            checks;
  int            failures;

  fu_wb_arbiter_if #(.NUM_FU(NF), .DATA_W(DW), .ADDR_W(AW), .ID_W(IW)) bus ();

  fu_wb_arbiter #(.NUM_FU(NF), .DATA_W(DW), .ADDR_W(AW), .ID_W(IW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .dbg_ptr (dbg_ptr)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  bit          mv    [NF];
  logic [AW-1:0] mrd [NF];
  logic [DW-1:0] mdata [NF];
  int          mptr;
  bit          movf;

  // First valid unit scanning from the pointer, -1 when nothing is buffered.
  function automatic int model_grant();
    int idx;
    for (int k = 0; k < NF; k++) begin
      idx = (mptr + k) % NF;
      if (mv[idx]) return idx;
    end
    return -1;
  endfunction

  // Applies one clock edge to the model using the inputs currently driven.
  task automatic model_clock();
    int g;
    g = model_grant();
    if (rst) begin
      for (int i = 0; i < NF; i++) mv[i] = 1'b0;
      mptr = 0;
      movf = 1'b0;
      return;
    end
    for (int i = 0; i < NF; i++) begin
      if (bus.fu_finish[i]) begin
        if (!mv[i] || g == i) begin
          mv[i]    = 1'b1;
          mrd[i]   = bus.fu_rd[i*AW +: AW];
          mdata[i] = bus.fu_data[i*DW +: DW];
        end else begin
          movf = 1'b1;
        end
      end else if (g == i) begin
        mv[i] = 1'b0;
      end
    end
    if (g >= 0) mptr = (g + 1) % NF;
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    bus.fu_finish = '0;
    bus.fu_rd     = '0;
    bus.fu_data   = '0;
  endtask

  task automatic set_fu(input int i, input logic [AW-1:0] r, input logic [DW-1:0] d);
    bus.fu_finish[i]       = 1'b1;
    bus.fu_rd[i*AW +: AW]  = r;
    bus.fu_data[i*DW +: DW] = d;
  endtask

  // Inputs change at negedge; DUT and model both advance on the posedge.
  task automatic tick();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.fu_finish = '1;
    for (int i = 0; i < NF; i++) begin
      bus.fu_rd[i*AW +: AW]   = AW'(i + 1);
      bus.fu_data[i*DW +: DW] = $urandom;
    end
    tick();
    rst = 1'b0;
    clear_inputs();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (bus.wb_en !== 1'b0) begin failures++; $display("FAIL reset_wb_en: got %0b want 0", bus.wb_en); end
    checks++; if (bus.wb_addr !== '0) begin failures++; $display("FAIL reset_wb_addr: got %0d want 0", bus.wb_addr); end
    checks++; if (bus.wb_data !== '0) begin failures++; $display("FAIL reset_wb_data: got %h want 0", bus.wb_data); end
    checks++; if (bus.retire_valid !== 1'b0) begin failures++; $display("FAIL reset_retire_valid: got %0b want 0", bus.retire_valid); end
    checks++; if (bus.retire_fu !== '0) begin failures++; $display("FAIL reset_retire_fu: got %0d want 0", bus.retire_fu); end
    checks++; if (bus.fu_hold !== '0) begin failures++; $display("FAIL reset_fu_hold: got %b want 0", bus.fu_hold); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %0b want 0", bus.overflow); end
    checks++; if (dbg_ptr !== '0) begin failures++; $display("FAIL reset_ptr: got %0d want 0", dbg_ptr); end
    tick();
    checks++; if (bus.retire_valid !== 1'b0) begin failures++; $display("FAIL reset_pulse_dropped: got retire_valid=%0b want 0", bus.retire_valid); end
  endtask

  task automatic test_single_jump();
    set_fu(4, 5'd1, 32'h0000_0108);
    tick();
    clear_inputs();
    checks++; if (bus.wb_en !== 1'b1) begin failures++; $display("FAIL jump_wb_en: got %0b want 1", bus.wb_en); end
    checks++; if (bus.wb_addr !== 5'd1) begin failures++; $display("FAIL jump_wb_addr: got %0d want 1", bus.wb_addr); end
    checks++; if (bus.wb_data !== 32'h108) begin failures++; $display("FAIL jump_wb_data: got %h want 108", bus.wb_data); end
    checks++; if (bus.retire_fu !== 3'd4) begin failures++; $display("FAIL jump_retire_fu: got %0d want 4", bus.retire_fu); end
    tick();
    checks++; if (bus.retire_valid !== 1'b0 || bus.wb_en !== 1'b0) begin failures++; $display("FAIL jump_idle: got rv=%0b en=%0b want 0 0", bus.retire_valid, bus.wb_en); end
    checks++; if (dbg_ptr !== 3'd0) begin failures++; $display("FAIL jump_ptr_wrap: got %0d want 0", dbg_ptr); end
  endtask

  task automatic test_simultaneous();
    set_fu(0, 5'd3, 32'hA);
    set_fu(3, 5'd4, 32'hB);
    tick();
    clear_inputs();
    checks++; if (bus.retire_fu !== 3'd0 || bus.wb_addr !== 5'd3 || bus.wb_data !== 32'hA) begin failures++; $display("FAIL simul_first: got fu=%0d addr=%0d data=%h want 0 3 a", bus.retire_fu, bus.wb_addr, bus.wb_data); end
    checks++; if (bus.fu_hold !== 5'b01000) begin failures++; $display("FAIL simul_hold: got %b want 01000", bus.fu_hold); end
    tick();
    checks++; if (bus.retire_fu !== 3'd3 || bus.wb_addr !== 5'd4 || bus.wb_data !== 32'hB) begin failures++; $display("FAIL simul_second: got fu=%0d addr=%0d data=%h want 3 4 b", bus.retire_fu, bus.wb_addr, bus.wb_data); end
    tick();
    checks++; if (bus.retire_valid !== 1'b0) begin failures++; $display("FAIL simul_idle: got %0b want 0", bus.retire_valid); end
  endtask

  task automatic test_rr_wrap();
    // Pointer is 4 after the previous scenario retired unit 3.
    set_fu(0, 5'd10, 32'h100);
    set_fu(4, 5'd11, 32'h104);
    tick();
    clear_inputs();
    checks++; if (dbg_ptr !== 3'd4) begin failures++; $display("FAIL wrap_ptr_start: got %0d want 4", dbg_ptr); end
    checks++; if (bus.retire_fu !== 3'd4 || bus.fu_hold !== 5'b00001) begin failures++; $display("FAIL wrap_first: got fu=%0d hold=%b want 4 00001", bus.retire_fu, bus.fu_hold); end
    tick();
    checks++; if (dbg_ptr !== 3'd0 || bus.retire_fu !== 3'd0 || bus.wb_addr !== 5'd10) begin failures++; $display("FAIL wrap_second: got ptr=%0d fu=%0d addr=%0d want 0 0 10", dbg_ptr, bus.retire_fu, bus.wb_addr); end
    tick();
  endtask

  task automatic test_x0();
    set_fu(2, 5'd0, 32'hFFFF_FFFF);
    tick();
    clear_inputs();
    checks++; if (bus.retire_valid !== 1'b1 || bus.retire_fu !== 3'd2) begin failures++; $display("FAIL x0_retire: got rv=%0b fu=%0d want 1 2", bus.retire_valid, bus.retire_fu); end
    checks++; if (bus.wb_en !== 1'b0) begin failures++; $display("FAIL x0_wb_en: got %0b want 0", bus.wb_en); end
    tick();
    checks++; if (bus.retire_valid !== 1'b0 || dbg_ptr !== 3'd3) begin failures++; $display("FAIL x0_freed: got rv=%0b ptr=%0d want 0 3", bus.retire_valid, dbg_ptr); end
  endtask

  task automatic test_overflow();
    // Pointer 3: units 3 and 4 outrank MEM (unit 1).
    set_fu(1, 5'd5, 32'h11);
    set_fu(3, 5'd6, 32'h33);
    set_fu(4, 5'd7, 32'h44);
    tick();
    clear_inputs();
    set_fu(1, 5'd9, 32'h22);
    checks++; if (bus.retire_fu !== 3'd3 || bus.overflow !== 1'b0) begin failures++; $display("FAIL ovf_pre: got fu=%0d ovf=%0b want 3 0", bus.retire_fu, bus.overflow); end
    tick();
    clear_inputs();
    checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_set: got %0b want 1", bus.overflow); end
    checks++; if (bus.retire_fu !== 3'd4 || bus.fu_hold !== 5'b00010) begin failures++; $display("FAIL ovf_next: got fu=%0d hold=%b want 4 00010", bus.retire_fu, bus.fu_hold); end
    tick();
    checks++; if (bus.retire_fu !== 3'd1 || bus.wb_addr !== 5'd5 || bus.wb_data !== 32'h11) begin failures++; $display("FAIL ovf_old_kept: got fu=%0d addr=%0d data=%h want 1 5 11", bus.retire_fu, bus.wb_addr, bus.wb_data); end
    tick();
    tick();
    checks++; if (bus.overflow !== 1'b1 || bus.retire_valid !== 1'b0) begin failures++; $display("FAIL ovf_sticky: got ovf=%0b rv=%0b want 1 0", bus.overflow, bus.retire_valid); end
    do_reset();
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL ovf_cleared: got %0b want 0", bus.overflow); end
  endtask

  task automatic test_refill();
    set_fu(0, 5'd7, 32'h1);
    tick();
    clear_inputs();
    set_fu(0, 5'd8, 32'h2);
    checks++; if (bus.retire_fu !== 3'd0 || bus.wb_addr !== 5'd7 || bus.wb_data !== 32'h1) begin failures++; $display("FAIL refill_first: got fu=%0d addr=%0d data=%h want 0 7 1", bus.retire_fu, bus.wb_addr, bus.wb_data); end
    tick();
    clear_inputs();
    checks++; if (bus.retire_valid !== 1'b1 || bus.retire_fu !== 3'd0 || bus.wb_addr !== 5'd8 || bus.wb_data !== 32'h2) begin failures++; $display("FAIL refill_second: got rv=%0b fu=%0d addr=%0d data=%h want 1 0 8 2", bus.retire_valid, bus.retire_fu, bus.wb_addr, bus.wb_data); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL refill_overflow: got %0b want 0", bus.overflow); end
    tick();
    checks++; if (bus.retire_valid !== 1'b0) begin failures++; $display("FAIL refill_idle: got %0b want 0", bus.retire_valid); end
  endtask

  task automatic test_random();
    int            g;
    logic          e_rv;
    logic          e_en;
    logic [IW-1:0] e_fu;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic [NF-1:0] e_hold;
    for (int cyc = 0; cyc < 600; cyc++) begin
      g      = model_grant();
      e_rv   = (g >= 0);
      e_fu   = e_rv ? IW'(g) : '0;
      e_addr = e_rv ? mrd[g] : '0;
      e_data = e_rv ? mdata[g] : '0;
      e_en   = e_rv && (e_addr != '0);
      for (int i = 0; i < NF; i++) e_hold[i] = mv[i] && (g != i);
      checks++; if (bus.retire_valid !== e_rv) begin failures++; $display("FAIL rand_retire_valid cyc=%0d: got %0b want %0b", cyc, bus.retire_valid, e_rv); end
      checks++; if (bus.retire_fu !== e_fu) begin failures++; $display("FAIL rand_retire_fu cyc=%0d: got %0d want %0d", cyc, bus.retire_fu, e_fu); end
      checks++; if (bus.wb_en !== e_en) begin failures++; $display("FAIL rand_wb_en cyc=%0d: got %0b want %0b", cyc, bus.wb_en, e_en); end
      checks++; if (bus.wb_addr !== e_addr) begin failures++; $display("FAIL rand_wb_addr cyc=%0d: got %0d want %0d", cyc, bus.wb_addr, e_addr); end
      checks++; if (bus.wb_data !== e_data) begin failures++; $display("FAIL rand_wb_data cyc=%0d: got %h want %h", cyc, bus.wb_data, e_data); end
      checks++; if (bus.fu_hold !== e_hold) begin failures++; $display("FAIL rand_fu_hold cyc=%0d: got %b want %b", cyc, bus.fu_hold, e_hold); end
      checks++; if (bus.overflow !== movf) begin failures++; $display("FAIL rand_overflow cyc=%0d: got %0b want %0b", cyc, bus.overflow, movf); end
      checks++; if (dbg_ptr !== IW'(mptr)) begin failures++; $display("FAIL rand_ptr cyc=%0d: got %0d want %0d", cyc, dbg_ptr, mptr); end
      rst = ($urandom_range(0, 59) == 0);
      clear_inputs();
      for (int i = 0; i < NF; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          set_fu(i, ($urandom_range(0, 3) == 0) ? 5'd0 : AW'($urandom_range(1, 31)), $urandom);
        end
      end
      tick();
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    mptr     = 0;
    movf     = 1'b0;
    for (int i = 0; i < NF; i++) begin
      mv[i]    = 1'b0;
      mrd[i]   = '0;
      mdata[i] = '0;
    end
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_single_jump();
    test_simultaneous();
    test_rr_wrap();
    test_x0();
    test_overflow();
    test_refill();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
